// File: rtl/delay_calibrator_pkg.sv
// Shared types for the I/O delay tap-sweep calibrator and the delay pair wrapper.
package delay_calibrator_pkg;

    localparam logic [1:0] DC_OP_NONE = 2'd0;
    localparam logic [1:0] DC_OP_LOAD = 2'd1;

    typedef struct packed {
        logic [1:0] op;
        logic       select;
        logic [8:0] value;
    } t_delay_config;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       locked;
        logic [8:0] center;
        logic [8:0] width;
    } t_cal_status;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SAMPLE,
        ST_EVAL,
        ST_FINAL_LOAD,
        ST_FINAL_SETTLE,
        ST_DONE
    } t_cal_state;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/delay_window_tracker.sv
// Tracks the current and best error-free tap runs and derives the window centre.
module delay_window_tracker
    import delay_calibrator_pkg::*;
#(
    parameter int TAP_STEP    = 8,
    parameter int DEFAULT_TAP = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clear,
    input  logic       eval,
    input  logic       step_good,
    input  logic [8:0] tap,
    output logic       locked,
    output logic [8:0] center,
    output logic [8:0] width
);

    localparam logic [9:0] TAP_INC = 10'(TAP_STEP);

    logic [9:0] cur_len_q, cur_len_d;
    logic [9:0] best_len_q, best_len_d;
    logic [8:0] cur_start_q, cur_start_d;
    logic [8:0] best_start_q, best_start_d;
    logic [9:0] span_s;

    // Run update on each evaluated step; ties keep the earlier window
    always_comb begin
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (clear) begin
            cur_len_d    = 10'd0;
            cur_start_d  = 9'd0;
            best_len_d   = 10'd0;
            best_start_d = 9'd0;
        end else if (eval) begin
            if (step_good) begin
                cur_len_d = cur_len_q + 10'd1;
                if (cur_len_q == 10'd0) begin
                    cur_start_d = tap;
                end else begin
                    cur_start_d = cur_start_q;
                end
            end else begin
                cur_len_d = 10'd0;
            end
            if (cur_len_d > best_len_q) begin
                best_len_d   = cur_len_d;
                best_start_d = cur_start_d;
            end else begin
                best_len_d   = best_len_q;
                best_start_d = best_start_q;
            end
        end else begin
            cur_len_d = cur_len_q;
        end
    end

    // Centre is derived from next-state values so the final load can use the last step
    always_comb begin
        span_s = 10'd0;
        if (best_len_d == 10'd0) begin
            locked = 1'b0;
            center = 9'(DEFAULT_TAP);
            width  = 9'd0;
        end else begin
            span_s = (best_len_d - 10'd1) * TAP_INC;
            locked = 1'b1;
            center = best_start_d + 9'(span_s >> 1);
            width  = best_len_d[9] ? 9'h1FF : best_len_d[8:0];
        end
    end

    // Run/best registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_len_q    <= 10'd0;
            cur_start_q  <= 9'd0;
            best_len_q   <= 10'd0;
            best_start_q <= 9'd0;
        end else if (enable) begin
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
        end
    end

endmodule

// File: rtl/delay_calibrator.sv
// Tap-sweep calibration sequencer driving the configuration port of a cascaded delay pair.
module delay_calibrator
    import delay_calibrator_pkg::*;
#(
    parameter int TAP_STEP      = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_CYCLES = 64,
    parameter int DEFAULT_TAP   = 0
) (
    input  logic       clk,
    input  logic       clk__enable,
    input  logic       reset_n,
    input  logic       cal_req__start,
    input  logic       cal_req__select,
    input  logic       sample__valid,
    input  logic       sample__ok,
    output logic [1:0] delay_config__op,
    output logic       delay_config__select,
    output logic [8:0] delay_config__value,
    output logic       cal_status__busy,
    output logic       cal_status__done,
    output logic       cal_status__locked,
    output logic [8:0] cal_status__center,
    output logic [8:0] cal_status__width
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [9:0]       TAP_INC     = 10'(TAP_STEP);

    t_cal_state      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]      tap_q, tap_d;
    logic [7:0]      err_q, err_d;
    t_delay_config   cfg_q, cfg_d;
    t_cal_status     stat_q, stat_d;
    logic            start_s;
    logic            eval_s;
    logic            trk_locked_s;
    logic [8:0]      trk_center_s;
    logic [8:0]      trk_width_s;

    assign start_s = cal_req__start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign eval_s  = (state_q == ST_EVAL);

    delay_window_tracker #(
        .TAP_STEP    (TAP_STEP),
        .DEFAULT_TAP (DEFAULT_TAP)
    ) u_tracker (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (clk__enable),
        .clear     (start_s),
        .eval      (eval_s),
        .step_good (err_q == 8'd0),
        .tap       (tap_q[8:0]),
        .locked    (trk_locked_s),
        .center    (trk_center_s),
        .width     (trk_width_s)
    );

    // Sequencer next state, step counters and error count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tap_d   = tap_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_s) begin
                    state_d = ST_LOAD;
                    tap_d   = 10'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
                cnt_d   = '0;
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                    err_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_SAMPLE: begin
                if (sample__valid && !sample__ok) begin
                    err_d = sat_inc8(err_q);
                end else begin
                    err_d = err_q;
                end
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = ST_EVAL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_EVAL: begin
                tap_d = tap_q + TAP_INC;
                if (tap_d > 10'd511) begin
                    state_d = ST_FINAL_LOAD;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FINAL_LOAD: begin
                state_d = ST_FINAL_SETTLE;
                cnt_d   = '0;
            end
            ST_FINAL_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are computed from the next state so they line up with it once registered
    always_comb begin
        cfg_d         = cfg_q;
        cfg_d.op      = DC_OP_NONE;
        stat_d        = stat_q;
        stat_d.busy   = (state_d != ST_IDLE) && (state_d != ST_DONE);
        stat_d.done   = 1'b0;
        if (start_s) begin
            cfg_d.select  = cal_req__select;
            stat_d.locked = 1'b0;
            stat_d.center = 9'd0;
            stat_d.width  = 9'd0;
        end else begin
            cfg_d.select = cfg_q.select;
        end
        case (state_d)
            ST_LOAD: begin
                cfg_d.op    = DC_OP_LOAD;
                cfg_d.value = tap_d[8:0];
            end
            ST_FINAL_LOAD: begin
                cfg_d.op    = DC_OP_LOAD;
                cfg_d.value = trk_center_s;
            end
            ST_DONE: begin
                if (state_q != ST_DONE) begin
                    stat_d.done   = 1'b1;
                    stat_d.locked = trk_locked_s;
                    stat_d.center = trk_center_s;
                    stat_d.width  = trk_width_s;
                end else begin
                    stat_d.done = 1'b0;
                end
            end
            default: begin
                cfg_d.op = DC_OP_NONE;
            end
        endcase
    end

    // State, counters and registered outputs; everything holds while disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tap_q   <= 10'd0;
            err_q   <= 8'd0;
            cfg_q   <= '0;
            stat_q  <= '0;
        end else if (clk__enable) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            err_q   <= err_d;
            cfg_q   <= cfg_d;
            stat_q  <= stat_d;
        end
    end

    assign delay_config__op     = cfg_q.op;
    assign delay_config__select = cfg_q.select;
    assign delay_config__value  = cfg_q.value;
    assign cal_status__busy     = stat_q.busy;
    assign cal_status__done     = stat_q.done;
    assign cal_status__locked   = stat_q.locked;
    assign cal_status__center   = stat_q.center;
    assign cal_status__width    = stat_q.width;

endmodule

// File: tb/tb_delay_calibrator.sv
// Bench for delay_calibrator: emulated pattern checker, load scoreboard and result table.
module tb_delay_calibrator;

    localparam int TAP_STEP = 64;
    localparam int SETTLE   = 2;
    localparam int SAMPLE   = 4;
    localparam int DEF_TAP  = 100;
    localparam int STEPS    = 512 / TAP_STEP;
    localparam int EXP_CYC  = STEPS * (SETTLE + SAMPLE + 2) + 1 + SETTLE + 1;

    logic       clk = 1'b0;
    logic       clk__enable = 1'b1;
    logic       reset_n = 1'b1;
    logic       cal_req__start = 1'b0;
    logic       cal_req__select = 1'b0;
    logic       sample__valid = 1'b0;
    logic       sample__ok = 1'b0;
    logic [1:0] delay_config__op;
    logic       delay_config__select;
    logic [8:0] delay_config__value;
    logic       cal_status__busy;
    logic       cal_status__done;
    logic       cal_status__locked;
    logic [8:0] cal_status__center;
    logic [8:0] cal_status__width;

    typedef struct {
        int lo1; int hi1; int lo2; int hi2;
        bit half_en; bit sel;
        bit exp_locked; int exp_width; int exp_center;
    } vec_t;

    vec_t vecs[5];
    int   checks = 0;
    int   errors = 0;
    int   expq[$];
    int   lo1 = 1, hi1 = 0, lo2 = 1, hi2 = 0;
    bit   half_en_mode = 1'b0;
    int   tap_cur = 0;
    int   post = 0;
    int   done_cnt = 0;
    int   last_load = 0;

    always #5 clk = ~clk;

    delay_calibrator #(
        .TAP_STEP      (TAP_STEP),
        .SETTLE_CYCLES (SETTLE),
        .SAMPLE_CYCLES (SAMPLE),
        .DEFAULT_TAP   (DEF_TAP)
    ) dut (
        .clk                  (clk),
        .clk__enable          (clk__enable),
        .reset_n              (reset_n),
        .cal_req__start       (cal_req__start),
        .cal_req__select      (cal_req__select),
        .sample__valid        (sample__valid),
        .sample__ok           (sample__ok),
        .delay_config__op     (delay_config__op),
        .delay_config__select (delay_config__select),
        .delay_config__value  (delay_config__value),
        .cal_status__busy     (cal_status__busy),
        .cal_status__done     (cal_status__done),
        .cal_status__locked   (cal_status__locked),
        .cal_status__center   (cal_status__center),
        .cal_status__width    (cal_status__width)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic bit tap_good(input int t);
        return ((t >= lo1) && (t <= hi1)) || ((t >= lo2) && (t <= hi2));
    endfunction

    // Emulated pattern checker: reports errors while the delay settles, then the tap's true result
    always @(negedge clk) begin
        bit en_v;
        en_v = half_en_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
        clk__enable = en_v;
        if (delay_config__op == 2'd1) begin
            tap_cur       = int'(delay_config__value);
            post          = 0;
            sample__valid = 1'b1;
            sample__ok    = 1'b0;
        end else if (post < SETTLE) begin
            sample__valid = 1'b1;
            sample__ok    = 1'b0;
            if (en_v) post++;
        end else begin
            if (((post - SETTLE) % 2) == 0) begin
                sample__valid = 1'b1;
                sample__ok    = tap_good(tap_cur);
            end else begin
                sample__valid = 1'b0;
                sample__ok    = 1'b0;
            end
            if (en_v && post < 1000) post++;
        end
    end

    // Scoreboard: every enabled load cycle pops one expected tap value
    always @(posedge clk) begin
        if (!reset_n) begin
            last_load = 0;
        end else if (clk__enable) begin
            if (delay_config__op != 2'd0) begin
                chk("op_enc", int'(delay_config__op), 1);
                if (expq.size() == 0) chk("load_unexpected", 1, 0);
                else chk("load_value", int'(delay_config__value), expq.pop_front());
                last_load = int'(delay_config__value);
            end else begin
                chk("value_hold", int'(delay_config__value), last_load);
            end
            if (cal_status__done) done_cnt++;
        end
    end

    task automatic run_vec(input int idx);
        vec_t v;
        int   cyc;
        int   g;
        bit   en;
        bit   seen;
        v = vecs[idx];
        lo1 = v.lo1; hi1 = v.hi1; lo2 = v.lo2; hi2 = v.hi2;
        half_en_mode = v.half_en;
        for (int k = 0; k < STEPS; k++) expq.push_back(k * TAP_STEP);
        expq.push_back(v.exp_center);
        done_cnt = 0;
        @(negedge clk);
        cal_req__start  = 1'b1;
        cal_req__select = v.sel;
        g = 0;
        do begin
            @(posedge clk);
            en = clk__enable;
            g++;
        end while (!en && g < 200);
        #1;
        chk("busy_rise", int'(cal_status__busy), 1);
        cyc = 1;
        @(negedge clk);
        cal_req__start = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 2000 && !seen; t++) begin
            @(posedge clk);
            en = clk__enable;
            #1;
            if (en) cyc++;
            if (cal_status__done) seen = 1'b1;
        end
        chk("done_seen", int'(seen), 1);
        chk("cycles", cyc, EXP_CYC);
        chk("busy_done", int'(cal_status__busy), 0);
        chk("locked", int'(cal_status__locked), int'(v.exp_locked));
        chk("width", int'(cal_status__width), v.exp_width);
        chk("center", int'(cal_status__center), v.exp_center);
        chk("select", int'(delay_config__select), int'(v.sel));
        chk("final_value", int'(delay_config__value), v.exp_center);
        half_en_mode = 1'b0;
        @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk("done_low", int'(cal_status__done), 0);
        chk("done_pulses", done_cnt, 1);
        chk("loads_left", expq.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_op"}, int'(delay_config__op), 0);
        chk({tag, "_sel"}, int'(delay_config__select), 0);
        chk({tag, "_value"}, int'(delay_config__value), 0);
        chk({tag, "_busy"}, int'(cal_status__busy), 0);
        chk({tag, "_done"}, int'(cal_status__done), 0);
        chk({tag, "_locked"}, int'(cal_status__locked), 0);
        chk({tag, "_center"}, int'(cal_status__center), 0);
        chk({tag, "_width"}, int'(cal_status__width), 0);
    endtask

    initial begin
        vecs[0] = '{128, 320, 1, 0, 1'b0, 1'b0, 1'b1, 4, 224};
        vecs[1] = '{0, 511, 1, 0, 1'b0, 1'b1, 1'b1, 8, 224};
        vecs[2] = '{1, 0, 1, 0, 1'b0, 1'b0, 1'b0, 0, DEF_TAP};
        vecs[3] = '{0, 64, 256, 320, 1'b0, 1'b1, 1'b1, 2, 32};
        vecs[4] = '{128, 320, 1, 0, 1'b1, 1'b1, 1'b1, 4, 224};

        #1 reset_n = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Start while busy is ignored, then reset lands in a SAMPLE phase
        half_en_mode = 1'b0;
        lo1 = 128; hi1 = 320; lo2 = 1; hi2 = 0;
        for (int k = 0; k < STEPS; k++) expq.push_back(k * TAP_STEP);
        expq.push_back(224);
        @(negedge clk);
        cal_req__start  = 1'b1;
        cal_req__select = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        cal_req__start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        cal_req__start  = 1'b1;
        cal_req__select = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cal_req__start = 1'b0;
        chk("busy_ignored_start", int'(cal_status__busy), 1);
        chk("sel_ignored_start", int'(delay_config__select), 1);
        chk("loads_before_reset", expq.size(), STEPS - 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        expq.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_after_reset_op", int'(delay_config__op), 0);
        chk("idle_after_reset_busy", int'(cal_status__busy), 0);

        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_calibrator.md
# delay_calibrator

Sequencer that owns the configuration port of one cascaded I/O delay pair and runs a tap-sweep calibration on request. It steps the delay value across the full 9-bit range, waits for each load to settle, and counts sample errors reported by an external pattern checker. It then loads the centre of the longest error-free tap window and reports the result. It sits between the per-lane training logic and the delay primitive wrapper, driving that wrapper's `delay_config__*` inputs.

## Interface
- `TAP_STEP`, default 8: tap increment per sweep step; power of two, 1..256.
- `SETTLE_CYCLES`, default 16: enabled cycles waited after each load; at least 1.
- `SAMPLE_CYCLES`, default 64: enabled cycles of error counting per step; at least 1.
- `DEFAULT_TAP`, default 0: value loaded when no error-free window is found.

Ports:
- `clk` in 1: single clock.
- `clk__enable` in 1: all state advances only when high; when low, every register and output holds.
- `reset_n` in 1: reset, asynchronous assert, active low.
- `cal_req__start` in 1: start a calibration; sampled in IDLE/DONE only.
- `cal_req__select` in 1: delay select; captured at start and driven on `delay_config__select`.
- `sample__valid` in 1: checker result valid this cycle.
- `sample__ok` in 1: checker compare passed; meaningful only with `sample__valid`.
- `delay_config__op` out 2: 0 = none, 1 = load; 2 and 3 are never driven.
- `delay_config__select` out 1: captured select.
- `delay_config__value` out 9: tap value to load.
- `cal_status__busy` out 1: high from the start cycle until DONE is entered.
- `cal_status__done` out 1: one-cycle pulse on entry to DONE.
- `cal_status__locked` out 1: an error-free window was found; held until the next start.
- `cal_status__center` out 9: tap value finally loaded; held.
- `cal_status__width` out 9: good-step count of the best window; held.

## Operation
- States:
  - IDLE: accepts start.
  - LOAD: `op`=1 for exactly one enabled cycle, `value`=tap.
  - SETTLE: count `SETTLE_CYCLES`.
  - SAMPLE: count `SAMPLE_CYCLES`; errors increment on `sample__valid && !sample__ok`.
  - EVAL: update runs, advance tap.
  - FINAL_LOAD: one-cycle load of the result.
  - FINAL_SETTLE: count `SETTLE_CYCLES`.
  - DONE: accepts start, as IDLE.
- Start captures select, clears tap, run and best registers, `locked`, `center` and `width`, then goes to LOAD.
- The tap counter is 10 bits. After EVAL, `tap += TAP_STEP`. If `tap > 511`, go to FINAL_LOAD; otherwise go to LOAD. Steps per sweep = 512/`TAP_STEP`.
- A step is good if and only if its error count is 0. The error counter saturates and does not wrap.
- Run tracking in EVAL:
  - Good step: `cur_len++`, with `cur_start=tap` if `cur_len` was 0.
  - Bad step: `cur_len=0`.
  - After the update, if `cur_len > best_len`, copy the current run to best. A strictly greater length is required, so on ties the earliest window wins.
- Result: `center = best_start + (((best_len-1)*TAP_STEP) >> 1)`, truncating. If `best_len == 0`, center is `DEFAULT_TAP` and locked is 0.
- The status outputs `center`, `width` and `locked` update on entry to DONE.
- Start while busy is ignored. No abort input exists; only reset stops a sweep.
- Reset mid-sweep: immediately returns to IDLE with all outputs at reset values. No load is issued.

## Timing
- Reset values:
  - `delay_config__op`=0, `__select`=0, `__value`=0.
  - `busy`=0, `done`=0, `locked`=0, `center`=0, `width`=0.
- All outputs are registered.
- `busy` rises the cycle after start is sampled. LOAD is the first state after start.
- Per step: 1 + `SETTLE_CYCLES` + `SAMPLE_CYCLES` + 1 enabled cycles.
- Total from start to the `done` pulse: steps × (`SETTLE_CYCLES` + `SAMPLE_CYCLES` + 2) + 1 + `SETTLE_CYCLES` + 1 enabled cycles.
- `delay_config__value` changes only in the LOAD and FINAL_LOAD cycles and holds otherwise.
- `sample__*` is ignored outside SAMPLE.
- Disabled cycles (`clk__enable`=0) are invisible: counts and pulses stretch, and `done` stays high until the next enabled edge.

## Structure
- Shared package contains:
  - the `delay_config` op encoding constants (NONE=0, LOAD=1);
  - a `t_delay_config` struct {op, select, value}, shared with the delay pair wrapper;
  - a `t_cal_status` struct;
  - the FSM state enum.
- Sub-module `delay_window_tracker` holds the run/best registers, the EVAL update and the centre arithmetic. The FSM and counters stay in the top.

## Test plan
- Run with `TAP_STEP`=64, `SETTLE`=2 and `SAMPLE`=4. Checker is ok only at taps 128–320. Required: loads 0, 64 … 448, then 224; `locked`=1, `width`=4, `center`=224.
- Checker is always ok, with `TAP_STEP`=64. Required: `width`=8, `center`=0+(7×64)/2=224.
- Checker is never ok. Required: final load of `DEFAULT_TAP`; `locked`=0, `width`=0, `done` pulses once.
- Two equal windows, at taps 0–64 and 256–320. Required: first wins, `center`=32.
- Toggle `clk__enable` at 50% during a sweep. Required: identical load sequence and result, with the elapsed enabled-cycle count matching the formula.
- Assert start again mid-sweep and it is ignored. Then reset during SAMPLE: all outputs return to 0 at once and a new start runs cleanly.
